l0_skew_feeder: RTL

//  Input staging buffer on the west edge of the mac_tile array.

---
 rtl/l0_skew_feeder.sv | 113 +++++++++++
 1 files changed

// File: rtl/l0_skew_feeder.sv
// Skewed west-edge staging buffer: one FIFO lane per array row, lane i replays i cycles after lane 0.
// Instructions ride a matching delay chain so in_w and inst_w reach each row's first tile together.
module l0_skew_feeder #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [row*bw-1:0]   in,
  input  logic                wr,
  input  logic                rd,
  input  logic [3:0]          inst_in,
  output logic [row*bw-1:0]   out,
  output logic [row*4-1:0]    inst_out,
  output logic [row-1:0]      o_valid,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_ready
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [row*bw-1:0] r_mem [depth];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr [row];
  logic [row-2:0]    r_rs;
  logic [3:0]        r_is   [row-1];
  logic [row*bw-1:0] r_out;
  logic [row*4-1:0]  r_inst;
  logic [row-1:0]    r_vld;

  logic              w_rs     [row];
  logic [3:0]        w_is     [row];
  logic [row-1:0]    w_pop;
  logic [bw-1:0]     w_lane_dat [row];
  logic              w_full;
  logic              w_wr_en;

  // Lane row-1 trails every other lane, so it alone bounds free space.
  assign w_full  = (r_wptr - r_rptr[row-1]) == PW'(depth);
  assign w_wr_en = wr & ~w_full;

  always_comb begin
    w_rs[0] = rd;
    w_is[0] = inst_in;
    for (int i = 1; i < row; i++) begin
      w_rs[i] = r_rs[i-1];
      w_is[i] = r_is[i-1];
    end
    for (int i = 0; i < row; i++) begin
      w_pop[i]      = w_rs[i] && (r_rptr[i] != r_wptr);
      w_lane_dat[i] = r_mem[r_rptr[i][AW-1:0]][i*bw +: bw];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[AW-1:0]] <= in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rs   <= '0;
      r_out  <= '0;
      r_inst <= '0;
      r_vld  <= '0;
      for (int i = 0; i < row; i++) begin
        r_rptr[i] <= '0;
      end
      for (int i = 0; i < row - 1; i++) begin
        r_is[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_rs[0] <= rd;
      r_is[0] <= inst_in;
      for (int i = 1; i < row - 1; i++) begin
        r_rs[i] <= r_rs[i-1];
        r_is[i] <= r_is[i-1];
      end
      for (int i = 0; i < row; i++) begin
        if (w_pop[i]) begin
          r_out[i*bw +: bw] <= w_lane_dat[i];
          r_vld[i]          <= 1'b1;
          r_inst[i*4 +: 4]  <= w_is[i];
          r_rptr[i]         <= r_rptr[i] + 1'b1;
        end else if (w_rs[i]) begin
          // Empty lane: data zeroed but the instruction still flows as a bubble.
          r_out[i*bw +: bw] <= '0;
          r_vld[i]          <= 1'b0;
          r_inst[i*4 +: 4]  <= w_is[i];
        end else begin
          r_vld[i]          <= 1'b0;
          r_inst[i*4 +: 4]  <= 4'b0000;
        end
      end
    end
  end

  assign out      = r_out;
  assign inst_out = r_inst;
  assign o_valid  = r_vld;
  assign o_full   = w_full;
  assign o_empty  = (r_rptr[0] == r_wptr);
  assign o_ready  = ~w_full;

endmodule
